// File: rtl/bg_pattern_gen.sv
// Background-write generator for SRAM BIST: sweeps every address once, ascending or
// descending, writing a solid/checker/row-stripe/col-stripe pattern with optional inversion.
module bg_pattern_gen #(
    parameter int AW = 8,
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [1:0]    mode,
    input  logic          invert,
    input  logic          descend,
    input  logic          mem_rdy,
    output logic          w_en,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] data,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [AW-1:0] ADDR_MAX = '1;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [1:0]    mode_q, mode_d;
    logic          invert_q, invert_d;
    logic          descend_q, descend_d;

    logic [AW-1:0] end_addr;
    logic [DW-1:0] alt;
    logic [DW-1:0] pattern;

    assign end_addr = descend_q ? '0 : ADDR_MAX;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_d   = state_q;
        addr_d    = addr_q;
        mode_d    = mode_q;
        invert_d  = invert_q;
        descend_d = descend_q;
        case (state_q)
            IDLE: begin
                addr_d = '0;
                if (start) begin
                    state_d   = WRITE;
                    mode_d    = mode;
                    invert_d  = invert;
                    descend_d = descend;
                    addr_d    = descend ? ADDR_MAX : '0;
                end
            end
            WRITE: begin
                if (mem_rdy) begin
                    if (addr_q == end_addr) begin
                        state_d = DONE;
                        addr_d  = '0;
                    end else begin
                        addr_d = descend_q ? addr_q - AW'(1) : addr_q + AW'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                addr_d  = '0;
            end
            default: begin
                state_d = IDLE;
                addr_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            mode_q    <= '0;
            invert_q  <= 1'b0;
            descend_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            state_q   <= state_d;
            addr_q    <= addr_d;
            mode_q    <= mode_d;
            invert_q  <= invert_d;
            descend_q <= descend_d;
        end
    end

    // ALT has odd bit positions set (e.g. 4'b1010); the row parity is the address LSB.
    always_comb begin
        alt = '0;
        for (int k = 0; k < DW; k++) begin
            alt[k] = ((k % 2) == 1);
        end
        case (mode_q)
            2'd0:    pattern = '0;
            2'd1:    pattern = alt ^ {DW{addr_q[0]}};
            2'd2:    pattern = {DW{addr_q[0]}};
            default: pattern = alt;
        endcase
    end

    assign w_en = (state_q == WRITE);
    assign busy = (state_q == WRITE);
    assign done = (state_q == DONE);
    assign addr = addr_q;
    assign data = (state_q == WRITE) ? (pattern ^ {DW{invert_q}}) : '0;

endmodule

// File: tb/tb_bg_pattern_gen.sv
// Directed bench for bg_pattern_gen: table of full sweeps plus hand sequences for
// mid-sweep reset and a small AW=3/DW=8 instance.
module tb_bg_pattern_gen;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, start2, invert, descend, mem_rdy;
    logic [1:0] mode;
    logic       w_en, busy, done;
    logic [7:0] addr;
    logic [3:0] data;
    logic       w_en2, busy2, done2;
    logic [2:0] addr2;
    logic [7:0] data2;

    bg_pattern_gen #(.AW(8), .DW(4)) u_dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .invert(invert),
        .descend(descend), .mem_rdy(mem_rdy), .w_en(w_en), .addr(addr),
        .data(data), .busy(busy), .done(done)
    );

    bg_pattern_gen #(.AW(3), .DW(8)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .mode(mode), .invert(invert),
        .descend(descend), .mem_rdy(mem_rdy), .w_en(w_en2), .addr(addr2),
        .data(data2), .busy(busy2), .done(done2)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Independent reference for the 4-bit backgrounds.
    function automatic logic [3:0] model(input logic [1:0] m, input logic inv, input logic [7:0] a);
        logic [3:0] d;
        case (m)
            2'd0:    d = 4'h0;
            2'd1:    d = a[0] ? 4'h5 : 4'hA;
            2'd2:    d = a[0] ? 4'hF : 4'h0;
            default: d = 4'hA;
        endcase
        return inv ? ~d : d;
    endfunction

    typedef struct {
        logic [1:0] m;
        logic       inv;
        logic       desc;
        int         stall;
        bit         restart;
        int         first_addr;
        int         first_data;
        int         second_data;
    } vec_t;

    vec_t vecs[8];

    int r_wen, r_busy, r_acc, r_done_k, r_done_n, r_at10, r_bad_data;
    int r_first_addr, r_first_data, r_second_data, r_last_addr;

    task automatic run_sweep(input logic [1:0] m, input logic inv, input logic desc,
                             input int stall_n, input bit restart);
        int  stalls;
        bit  seen_first, seen_second;
        r_wen = 0; r_busy = 0; r_acc = 0; r_done_k = 0; r_done_n = 0; r_at10 = 0;
        r_bad_data = 0; r_first_addr = -1; r_first_data = -1; r_second_data = -1;
        r_last_addr = -1; seen_first = 0; seen_second = 0; stalls = stall_n;
        mode = m; invert = inv; descend = desc; mem_rdy = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 600; k++) begin
            mem_rdy = 1'b1;
            if (w_en) begin
                r_wen++;
                if (!seen_first) begin
                    r_first_addr = int'(addr); r_first_data = int'(data); seen_first = 1;
                end else if (!seen_second && int'(addr) != r_first_addr) begin
                    r_second_data = int'(data); seen_second = 1;
                end
                if (data !== model(m, inv, addr)) r_bad_data++;
                if (addr == 8'd10) begin
                    r_at10++;
                    if (stalls > 0) begin
                        mem_rdy = 1'b0;
                        stalls--;
                    end
                end
                if (mem_rdy) begin
                    r_acc++;
                    r_last_addr = int'(addr);
                end
            end
            if (busy) r_busy++;
            if (done) begin
                r_done_n++;
                if (r_done_k == 0) r_done_k = k;
            end
            if (restart && k == 50) begin
                start = 1'b1; mode = ~m; invert = ~inv; descend = ~desc;
            end else if (restart && done) begin
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (r_done_k != 0 && k >= r_done_k + 5) break;
            tick();
        end
        start = 1'b0;
        mem_rdy = 1'b1;
    endtask

    initial begin
        int hit, n_wen, n_done, dk, n2, f2, s2, l2;
        rst = 1'b1; start = 1'b0; start2 = 1'b0; mode = 2'd0; invert = 1'b0;
        descend = 1'b0; mem_rdy = 1'b1;

        vecs[0] = '{2'd0, 1'b0, 1'b0, 0, 1'b0,   0, 4'h0, 4'h0};
        vecs[1] = '{2'd0, 1'b1, 1'b1, 0, 1'b0, 255, 4'hF, 4'hF};
        vecs[2] = '{2'd1, 1'b0, 1'b0, 0, 1'b0,   0, 4'hA, 4'h5};
        vecs[3] = '{2'd2, 1'b1, 1'b0, 0, 1'b0,   0, 4'hF, 4'h0};
        vecs[4] = '{2'd3, 1'b0, 1'b1, 0, 1'b0, 255, 4'hA, 4'hA};
        vecs[5] = '{2'd1, 1'b1, 1'b1, 0, 1'b0, 255, 4'hA, 4'h5};
        vecs[6] = '{2'd1, 1'b0, 1'b0, 3, 1'b0,   0, 4'hA, 4'h5};
        vecs[7] = '{2'd2, 1'b0, 1'b1, 0, 1'b1, 255, 4'hF, 4'h0};

        tick();
        tick();
        check("reset w_en", 32'(w_en), 0);
        check("reset busy", 32'(busy), 0);
        check("reset done", 32'(done), 0);
        check("reset addr", 32'(addr), 0);
        check("reset data", 32'(data), 0);
        check("reset w_en2", 32'(w_en2), 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) begin
            run_sweep(vecs[i].m, vecs[i].inv, vecs[i].desc, vecs[i].stall, vecs[i].restart);
            check($sformatf("v%0d first_addr", i), r_first_addr, vecs[i].first_addr);
            check($sformatf("v%0d first_data", i), r_first_data, vecs[i].first_data);
            check($sformatf("v%0d second_data", i), r_second_data, vecs[i].second_data);
            check($sformatf("v%0d last_addr", i), r_last_addr, vecs[i].desc ? 0 : 255);
            check($sformatf("v%0d data_errors", i), r_bad_data, 0);
            check($sformatf("v%0d accepts", i), r_acc, 256);
            check($sformatf("v%0d wen_cycles", i), r_wen, 256 + vecs[i].stall);
            check($sformatf("v%0d busy_cycles", i), r_busy, 256 + vecs[i].stall);
            check($sformatf("v%0d done_cycle", i), r_done_k, 257 + vecs[i].stall);
            check($sformatf("v%0d done_pulses", i), r_done_n, 1);
            if (vecs[i].desc == 1'b0)
                check($sformatf("v%0d cycles_at_10", i), r_at10, 1 + vecs[i].stall);
        end

        // Reset mid-sweep at addr 100 aborts the sweep with no done pulse.
        mode = 2'd1; invert = 1'b0; descend = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        hit = 0;
        for (int k = 0; k < 300; k++) begin
            if (w_en && addr == 8'd100) begin
                hit = 1;
                break;
            end
            tick();
        end
        check("abort reached addr 100", hit, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort w_en", 32'(w_en), 0);
        check("abort busy", 32'(busy), 0);
        check("abort addr", 32'(addr), 0);
        check("abort done", 32'(done), 0);
        check("abort data", 32'(data), 0);
        n_wen = 0; n_done = 0;
        for (int k = 0; k < 300; k++) begin
            tick();
            if (w_en) n_wen++;
            if (done) n_done++;
        end
        check("abort no further writes", n_wen, 0);
        check("abort no done pulse", n_done, 0);
        run_sweep(2'd0, 1'b0, 1'b0, 0, 1'b0);
        check("after abort first_addr", r_first_addr, 0);
        check("after abort wen_cycles", r_wen, 256);
        check("after abort done_cycle", r_done_k, 257);

        // Small instance: AW=3, DW=8 checkerboard, with a start re-pulse mid-sweep.
        mode = 2'd1; invert = 1'b0; descend = 1'b0; start2 = 1'b1;
        tick();
        start2 = 1'b0;
        n2 = 0; f2 = -1; s2 = -1; l2 = -1; dk = 0; n_done = 0;
        for (int k = 1; k <= 40; k++) begin
            if (w_en2) begin
                n2++;
                if (n2 == 1) f2 = int'(data2);
                if (n2 == 2) s2 = int'(data2);
                l2 = int'(addr2);
            end
            if (done2) begin
                n_done++;
                if (dk == 0) dk = k;
            end
            start2 = (k == 3) || done2;
            if (dk != 0 && k >= dk + 3) break;
            tick();
        end
        start2 = 1'b0;
        check("small writes", n2, 8);
        check("small addr0 data", f2, 8'hAA);
        check("small addr1 data", s2, 8'h55);
        check("small last addr", l2, 7);
        check("small done cycle", dk, 9);
        check("small done pulses", n_done, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
